duck_ctrl: RTL and testbench



---
 rtl/duck_pkg.sv | 24 ++
 rtl/duck_jump_phys.sv | 51 +++++
 rtl/duck_ctrl.sv | 160 ++++++++++++++++
 tb/tb_duck_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared encodings for the duck player controller: FSM states, bitmap selects
// and the score width.
package duck_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        JUMP = 3'd2,
        DUCK = 3'd3,
        DEAD = 3'd4
    } state_t;

    localparam logic [1:0] SEL_STAND  = 2'd0;
    localparam logic [1:0] SEL_CROUCH = 2'd1;
    localparam logic [1:0] SEL_DEAD   = 2'd2;

    localparam int SCORE_W = 16;

    // States in which the player is alive, scoring and vulnerable to hits.
    function automatic logic is_live(state_t s);
        return (s == RUN) || (s == JUMP) || (s == DUCK);
    endfunction

endpackage

// File: rtl/duck_jump_phys.sv
// Height / vertical-velocity integrator for the duck's jump. A load starts a
// jump (first frame of climb already applied), each step integrates one frame
// of gravity, and clear returns the duck to the ground.
module duck_jump_phys #(
    parameter int CORDW   = 12,
    parameter int JUMP_V  = 12,
    parameter int GRAVITY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fast,
    input  logic             clear,
    output logic [CORDW:0]   height,
    output logic             landed
);

    logic signed [7:0]     vy;
    logic signed [7:0]     vy_next;
    logic signed [CORDW:0] vy_ext;
    logic signed [CORDW:0] h_next;

    // Next-frame trajectory; landed means a step taken now reaches the ground.
    always_comb begin
        vy_ext  = {{(CORDW - 7){vy[7]}}, vy};
        h_next  = $signed(height) + vy_ext;
        vy_next = fast ? (vy - 8'(2 * GRAVITY)) : (vy - 8'(GRAVITY));
        landed  = h_next[CORDW] || (h_next == '0);
    end

    // Integrator registers; height is clamped to the ground on touchdown.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            height <= '0;
            vy     <= '0;
        end else if (load) begin
            height <= (CORDW + 1)'(JUMP_V);
            vy     <= 8'(JUMP_V - GRAVITY);
        end else if (step) begin
            if (landed) begin
                height <= '0;
                vy     <= '0;
            end else begin
                height <= h_next;
                vy     <= vy_next;
            end
        end
    end

endmodule

// File: rtl/duck_ctrl.sv
// Frame-rate player controller: run / jump / crouch / death FSM, hit latch,
// death blink counter and survival score, driving one sprite engine.
module duck_ctrl
    import duck_pkg::*;
#(
    parameter int CORDW        = 12,
    parameter int DUCK_X       = 64,
    parameter int GROUND_Y     = 400,
    parameter int STAND_H      = 32,
    parameter int CROUCH_H     = 16,
    parameter int JUMP_V       = 12,
    parameter int GRAVITY      = 1,
    parameter int BLINK_FRAMES = 8,
    parameter int DEAD_FRAMES  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame,
    input  logic               btn_jump,
    input  logic               btn_duck,
    input  logic               hit,
    output logic [CORDW-1:0]   sprx,
    output logic [CORDW-1:0]   spry,
    output logic               spr_en,
    output logic [1:0]         spr_sel,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state
);

    localparam int CNT_W = $clog2(DEAD_FRAMES + 1);

    state_t                state_q;
    state_t                state_d;
    logic                  hit_q;
    logic                  hit_any;
    logic                  jump_prev;
    logic                  jump_press;
    logic [CNT_W-1:0]      dead_cnt;
    logic                  dead_done;
    logic                  blink_tick;
    logic                  phys_load;
    logic                  phys_step;
    logic                  phys_clear;
    logic                  landed;
    logic [CORDW:0]        height;
    logic signed [CORDW:0] stand_top;

    duck_jump_phys #(
        .CORDW   (CORDW),
        .JUMP_V  (JUMP_V),
        .GRAVITY (GRAVITY)
    ) u_phys (
        .clk    (clk),
        .rst    (rst),
        .load   (phys_load),
        .step   (phys_step),
        .fast   (btn_duck),
        .clear  (phys_clear),
        .height (height),
        .landed (landed)
    );

    // Next-state decode; a hit (latched or arriving this cycle) beats everything.
    always_comb begin
        state_d    = state_q;
        jump_press = btn_jump & ~jump_prev;
        hit_any    = hit_q | hit;
        dead_done  = (dead_cnt == CNT_W'(DEAD_FRAMES - 1));
        blink_tick = ((dead_cnt % CNT_W'(BLINK_FRAMES)) == CNT_W'(BLINK_FRAMES - 1));
        case (state_q)
            IDLE: if (jump_press) state_d = RUN;
            RUN: begin
                if (hit_any)         state_d = DEAD;
                else if (jump_press) state_d = JUMP;
                else if (btn_duck)   state_d = DUCK;
            end
            DUCK: begin
                if (hit_any)        state_d = DEAD;
                else if (!btn_duck) state_d = RUN;
            end
            JUMP: begin
                if (hit_any)     state_d = DEAD;
                else if (landed) state_d = btn_duck ? DUCK : RUN;
            end
            DEAD: if (dead_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        phys_load  = frame && (state_q == RUN) && (state_d == JUMP);
        phys_step  = frame && (state_q == JUMP) && (state_d != DEAD);
        phys_clear = frame && (state_d == IDLE);
    end

    // State register, jump edge history and bitmap select advance per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            jump_prev <= 1'b0;
            spr_sel   <= SEL_STAND;
        end else if (frame) begin
            state_q   <= state_d;
            jump_prev <= btn_jump;
            case (state_d)
                DEAD:    spr_sel <= SEL_DEAD;
                DUCK:    spr_sel <= SEL_CROUCH;
                default: spr_sel <= SEL_STAND;
            endcase
        end
    end

    // Hit latch catches strobes between frames while alive; cleared on death.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else if (frame && (state_d == DEAD) && (state_q != DEAD)) begin
            hit_q <= 1'b0;
        end else if (hit && is_live(state_q)) begin
            hit_q <= 1'b1;
        end
    end

    // Death timer and blink: toggle the sprite every BLINK_FRAMES while dead.
    always_ff @(posedge clk) begin
        if (rst) begin
            dead_cnt <= '0;
            spr_en   <= 1'b1;
        end else if (frame) begin
            if (state_q == DEAD && state_d == DEAD) begin
                dead_cnt <= dead_cnt + 1'b1;
                if (blink_tick) spr_en <= ~spr_en;
            end else begin
                dead_cnt <= '0;
                spr_en   <= 1'b1;
            end
        end
    end

    // Survival score: cleared on game start, saturating count of live frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else if (frame) begin
            if (state_q == IDLE && state_d == RUN) begin
                score <= '0;
            end else if (is_live(state_q) && (score != '1)) begin
                score <= score + 1'b1;
            end
        end
    end

    // Sprite position is decoded only from registers, so it changes solely on the edge after a frame.
    always_comb begin
        stand_top = (CORDW + 1)'(GROUND_Y - STAND_H) - $signed(height);
        spry      = (spr_sel == SEL_CROUCH) ? CORDW'(GROUND_Y - CROUCH_H)
                                            : stand_top[CORDW-1:0];
    end

    assign sprx  = CORDW'(DUCK_X);
    assign state = state_q;

endmodule

// File: tb/tb_duck_ctrl.sv
// Directed testbench for duck_ctrl with default parameters.
module tb_duck_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame = 1'b0;
    logic        btn_jump = 1'b0;
    logic        btn_duck = 1'b0;
    logic        hit = 1'b0;
    logic [11:0] sprx;
    logic [11:0] spry;
    logic        spr_en;
    logic [1:0]  spr_sel;
    logic [15:0] score;
    logic [2:0]  state;

    int passed = 0;
    int total  = 0;

    duck_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .frame    (frame),
        .btn_jump (btn_jump),
        .btn_duck (btn_duck),
        .hit      (hit),
        .sprx     (sprx),
        .spry     (spry),
        .spr_en   (spr_en),
        .spr_sel  (spr_sel),
        .score    (score),
        .state    (state)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // One frame pulse, then an idle cycle; returns at a negedge with outputs settled.
    task automatic do_frame();
        @(negedge clk) frame = 1'b1;
        @(negedge clk) frame = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) do_frame();
        total++; if (state !== 3'd0) $display("[TB] FAIL reset_state got %0d want 0", state); else passed++;
        total++; if (sprx !== 12'd64) $display("[TB] FAIL reset_sprx got %0d want 64", sprx); else passed++;
        total++; if (spry !== 12'd368) $display("[TB] FAIL reset_spry got %0d want 368", spry); else passed++;
        total++; if (spr_en !== 1'b1) $display("[TB] FAIL reset_en got %0b want 1", spr_en); else passed++;
        total++; if (spr_sel !== 2'd0) $display("[TB] FAIL reset_sel got %0d want 0", spr_sel); else passed++;
        total++; if (score !== 16'd0) $display("[TB] FAIL reset_score got %0d want 0", score); else passed++;
    endtask

    task automatic test_start_run();
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        total++; if (state !== 3'd1) $display("[TB] FAIL start_state got %0d want 1", state); else passed++;
        total++; if (score !== 16'd0) $display("[TB] FAIL start_score got %0d want 0", score); else passed++;
        repeat (10) do_frame();
        total++; if (score !== 16'd10) $display("[TB] FAIL run_score got %0d want 10", score); else passed++;
        total++; if (spry !== 12'd368) $display("[TB] FAIL run_spry got %0d want 368", spry); else passed++;
        total++; if (state !== 3'd1) $display("[TB] FAIL run_state got %0d want 1", state); else passed++;
    endtask

    task automatic test_jump();
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        total++; if (state !== 3'd2) $display("[TB] FAIL jump_state got %0d want 2", state); else passed++;
        total++; if (spry !== 12'd356) $display("[TB] FAIL jump_first_spry got %0d want 356", spry); else passed++;
        total++; if (score !== 16'd11) $display("[TB] FAIL jump_score got %0d want 11", score); else passed++;
        repeat (11) do_frame();
        total++; if (spry !== 12'd290) $display("[TB] FAIL jump_peak_spry got %0d want 290", spry); else passed++;
        repeat (12) do_frame();
        total++; if (spry !== 12'd356) $display("[TB] FAIL jump_f24_spry got %0d want 356", spry); else passed++;
        total++; if (state !== 3'd2) $display("[TB] FAIL jump_f24_state got %0d want 2", state); else passed++;
        do_frame();
        total++; if (spry !== 12'd368) $display("[TB] FAIL land_spry got %0d want 368", spry); else passed++;
        total++; if (state !== 3'd1) $display("[TB] FAIL land_state got %0d want 1", state); else passed++;
        total++; if (score !== 16'd35) $display("[TB] FAIL land_score got %0d want 35", score); else passed++;
    endtask

    task automatic test_duck();
        btn_duck = 1'b1;
        do_frame();
        total++; if (state !== 3'd3) $display("[TB] FAIL duck_state got %0d want 3", state); else passed++;
        total++; if (spr_sel !== 2'd1) $display("[TB] FAIL duck_sel got %0d want 1", spr_sel); else passed++;
        total++; if (spry !== 12'd384) $display("[TB] FAIL duck_spry got %0d want 384", spry); else passed++;
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        total++; if (state !== 3'd3) $display("[TB] FAIL duck_jump_ignored got %0d want 3", state); else passed++;
        btn_duck = 1'b0;
        do_frame();
        total++; if (state !== 3'd1) $display("[TB] FAIL unduck_state got %0d want 1", state); else passed++;
        total++; if (spry !== 12'd368) $display("[TB] FAIL unduck_spry got %0d want 368", spry); else passed++;
        total++; if (score !== 16'd38) $display("[TB] FAIL duck_score got %0d want 38", score); else passed++;
    endtask

    task automatic test_fast_fall();
        int n;
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        btn_duck = 1'b1;
        n = 1;
        while (n < 40 && state !== 3'd3) begin
            do_frame();
            n++;
        end
        total++; if (n !== 14) $display("[TB] FAIL fast_fall_frames got %0d want 14", n); else passed++;
        total++; if (spry !== 12'd384) $display("[TB] FAIL fast_fall_spry got %0d want 384", spry); else passed++;
        btn_duck = 1'b0;
        do_frame();
        total++; if (state !== 3'd1) $display("[TB] FAIL fast_fall_run got %0d want 1", state); else passed++;
        total++; if (score !== 16'd53) $display("[TB] FAIL fast_fall_score got %0d want 53", score); else passed++;
    endtask

    task automatic test_hit_death();
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        repeat (2) do_frame();
        total++; if (spry !== 12'd335) $display("[TB] FAIL prehit_spry got %0d want 335", spry); else passed++;
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (state !== 3'd2) $display("[TB] FAIL hit_wait_state got %0d want 2", state); else passed++;
        do_frame();
        total++; if (state !== 3'd4) $display("[TB] FAIL dead_state got %0d want 4", state); else passed++;
        total++; if (spr_sel !== 2'd2) $display("[TB] FAIL dead_sel got %0d want 2", spr_sel); else passed++;
        total++; if (spry !== 12'd335) $display("[TB] FAIL dead_spry got %0d want 335", spry); else passed++;
        total++; if (score !== 16'd57) $display("[TB] FAIL dead_score got %0d want 57", score); else passed++;
        btn_jump = 1'b1;
        for (int f = 1; f <= 64; f++) begin
            if (f == 20) begin
                @(negedge clk) hit = 1'b1;
                @(negedge clk) hit = 1'b0;
            end
            do_frame();
            if (f == 7) begin
                total++; if (spr_en !== 1'b1) $display("[TB] FAIL blink_f7 got %0b want 1", spr_en); else passed++;
            end
            if (f == 8) begin
                total++; if (spr_en !== 1'b0) $display("[TB] FAIL blink_f8 got %0b want 0", spr_en); else passed++;
            end
            if (f == 15) begin
                total++; if (spr_en !== 1'b0) $display("[TB] FAIL blink_f15 got %0b want 0", spr_en); else passed++;
            end
            if (f == 16) begin
                total++; if (spr_en !== 1'b1) $display("[TB] FAIL blink_f16 got %0b want 1", spr_en); else passed++;
            end
            if (f == 63) begin
                total++; if (state !== 3'd4) $display("[TB] FAIL dead_f63_state got %0d want 4", state); else passed++;
                total++; if (spr_en !== 1'b0) $display("[TB] FAIL blink_f63 got %0b want 0", spr_en); else passed++;
                total++; if (spry !== 12'd335) $display("[TB] FAIL dead_f63_spry got %0d want 335", spry); else passed++;
            end
        end
        total++; if (state !== 3'd0) $display("[TB] FAIL revive_state got %0d want 0", state); else passed++;
        total++; if (spr_en !== 1'b1) $display("[TB] FAIL revive_en got %0b want 1", spr_en); else passed++;
        total++; if (score !== 16'd57) $display("[TB] FAIL revive_score got %0d want 57", score); else passed++;
        total++; if (spry !== 12'd368) $display("[TB] FAIL revive_spry got %0d want 368", spry); else passed++;
        do_frame();
        total++; if (state !== 3'd0) $display("[TB] FAIL held_jump_state got %0d want 0", state); else passed++;
        btn_jump = 1'b0;
        do_frame();
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        total++; if (state !== 3'd1) $display("[TB] FAIL restart_state got %0d want 1", state); else passed++;
        total++; if (score !== 16'd0) $display("[TB] FAIL restart_score got %0d want 0", score); else passed++;
        repeat (3) do_frame();
        total++; if (state !== 3'd1) $display("[TB] FAIL no_stale_hit got %0d want 1", state); else passed++;
        total++; if (score !== 16'd3) $display("[TB] FAIL restart_run_score got %0d want 3", score); else passed++;
    endtask

    task automatic test_reset_mid_jump();
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        repeat (11) do_frame();
        total++; if (spry !== 12'd290) $display("[TB] FAIL rj_peak_spry got %0d want 290", spry); else passed++;
        @(negedge clk);
        rst   = 1'b1;
        frame = 1'b1;
        hit   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        frame = 1'b0;
        hit   = 1'b0;
        total++; if (state !== 3'd0) $display("[TB] FAIL rj_state got %0d want 0", state); else passed++;
        total++; if (spry !== 12'd368) $display("[TB] FAIL rj_spry got %0d want 368", spry); else passed++;
        total++; if (score !== 16'd0) $display("[TB] FAIL rj_score got %0d want 0", score); else passed++;
        total++; if (spr_en !== 1'b1) $display("[TB] FAIL rj_en got %0b want 1", spr_en); else passed++;
        btn_jump = 1'b1;
        do_frame();
        btn_jump = 1'b0;
        do_frame();
        total++; if (state !== 3'd1) $display("[TB] FAIL rj_hit_clear got %0d want 1", state); else passed++;
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_jump();
        test_duck();
        test_fast_fall();
        test_hit_death();
        test_reset_mid_jump();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
